// File: rtl/ysyx_25030093_pkg.sv
// Shared types and defaults for the inter-stage elastic buffers of the core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default buffer depth, the per-stage payload structs used to size
// DATA_W via $bits, and a helper giving the pointer width for a given depth.
package ysyx_25030093_pkg;

   localparam int unsigned STAGE_BUF_DEPTH = 2;

   // IFU -> IDU payload
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } if_id_t;

   // IDU -> EXU payload
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
   } id_ex_t;

   // EXU -> WBU payload
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] result;
      logic [4:0]  rd;
      logic        wen;
   } ex_wb_t;

   // A single-entry buffer still needs a 1-bit pointer to index its array.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ysyx_25030093_buf_mem.sv
// Storage array for the stage buffer: DEPTH x DATA_W registers.
// Latency: write visible on the read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller guarantees waddr_i/raddr_i stay below DEPTH.
//
// Ports: clk_i, we_i/waddr_i/wdata_i (synchronous write), raddr_i/rdata_o
// (asynchronous read). Contents are not reset; the owner masks stale data.
module ysyx_25030093_buf_mem
   import ysyx_25030093_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned PTR_W  = ptr_w(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [PTR_W-1:0]  waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [PTR_W-1:0]  raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ysyx_25030093_stage_buf.sv
// Elastic FIFO buffer between two pipeline stages with synchronous flush.
// Latency: push in cycle N is visible on out_* in N+1 (0 with the bypass build).
// Backpressure: in_ready depends only on registered occupancy; full blocks input even when popping.
//
// Ports: clk, rst (sync, active-high), flush; producer side in_valid/in_ready/
// in_data; consumer side out_valid/out_ready/out_data; count = stored entries.
// Build option YSYX_25030093_STAGE_BYPASS_EN: when empty and the consumer is
// ready, input passes straight to the output without being stored.
module ysyx_25030093_stage_buf
   import ysyx_25030093_pkg::*;
#(
   parameter int unsigned DATA_W = $bits(if_id_t),
   parameter int unsigned DEPTH  = STAGE_BUF_DEPTH,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned      PTR_W    = ptr_w(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] head_data;
   logic              not_empty;
   logic              not_full;
   logic              bypass;
   logic              push;
   logic              pop;

   assign not_empty = (count_q != '0);
   assign not_full  = (count_q < CNT_FULL);

   // Held low through reset so the producer never sees a handshake that the
   // reset is about to discard.
   assign in_ready  = not_full && !rst;

`ifdef YSYX_25030093_STAGE_BYPASS_EN
   assign bypass    = !rst && !flush && !not_empty && in_valid && out_ready;
   assign out_valid = not_empty || bypass;
   assign out_data  = bypass    ? in_data   :
                      not_empty ? head_data : '0;
`else
   assign bypass    = 1'b0;
   assign out_valid = not_empty;
   assign out_data  = not_empty ? head_data : '0;
`endif

   // A bypassed transfer completes at the output, so it is never stored.
   assign push = in_valid && in_ready && !flush && !bypass;
   assign pop  = not_empty && out_ready && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         // Storage is left as-is; zero count masks whatever it holds.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;

   ysyx_25030093_buf_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .PTR_W  (PTR_W)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data),
      .raddr_i (rd_ptr_q),
      .rdata_o (head_data)
   );

endmodule

// File: tb/tb_ysyx_25030093_stage_buf.sv
// Bench for the stage buffer: two instances (DEPTH=2 and DEPTH=3) share one
// stimulus stream; each has a queue-based reference model and checker.
// Directed phases (reset, fill/drain, simultaneous, flush, bypass, wrap) are
// followed by a randomized phase with occasional reset and flush.
module tb_ysyx_25030093_stage_buf;

`ifdef YSYX_25030093_STAGE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;

   logic        rdy2, vld2, rdy3, vld3;
   logic [63:0] dat2, dat3;
   logic [1:0]  cnt2, cnt3;

   int          total;
   int          bad;
   bit          chk_en;

   logic [63:0] m2 [$];
   logic [63:0] m3 [$];

   ysyx_25030093_stage_buf #(.DATA_W(64), .DEPTH(2)) u_d2 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (rdy2),
      .in_data   (in_data),
      .out_valid (vld2),
      .out_ready (out_ready),
      .out_data  (dat2),
      .count     (cnt2)
   );

   ysyx_25030093_stage_buf #(.DATA_W(64), .DEPTH(3)) u_d3 (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (rdy3),
      .in_data   (in_data),
      .out_valid (vld3),
      .out_ready (out_ready),
      .out_data  (dat3),
      .count     (cnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   // Reference model / scoreboard, DEPTH=2. Inputs are stable at negedge, so
   // the expected outputs for this cycle are derived from the queue, then the
   // queue is advanced to what the buffer should hold after the next edge.
   always @(negedge clk) begin : mdl2
      logic        e_rdy, e_vld, byp;
      logic [63:0] e_dat;
      byp   = BYP && !rst && !flush && (m2.size() == 0) && in_valid && out_ready;
      e_rdy = !rst && (m2.size() < 2);
      e_vld = byp || (m2.size() != 0);
      e_dat = byp ? in_data : ((m2.size() != 0) ? m2[0] : 64'd0);
      if (chk_en) begin
         chk("d2_in_ready",  {63'd0, rdy2}, {63'd0, e_rdy});
         chk("d2_out_valid", {63'd0, vld2}, {63'd0, e_vld});
         chk("d2_out_data",  dat2, e_dat);
         chk("d2_count",     {62'd0, cnt2}, 64'(m2.size()));
      end
      if (rst || flush) begin
         m2.delete();
      end else if (!byp) begin
         if ((m2.size() != 0) && out_ready) void'(m2.pop_front());
         if (in_valid && e_rdy) m2.push_back(in_data);
      end
   end

   // Reference model / scoreboard, DEPTH=3.
   always @(negedge clk) begin : mdl3
      logic        e_rdy, e_vld, byp;
      logic [63:0] e_dat;
      byp   = BYP && !rst && !flush && (m3.size() == 0) && in_valid && out_ready;
      e_rdy = !rst && (m3.size() < 3);
      e_vld = byp || (m3.size() != 0);
      e_dat = byp ? in_data : ((m3.size() != 0) ? m3[0] : 64'd0);
      if (chk_en) begin
         chk("d3_in_ready",  {63'd0, rdy3}, {63'd0, e_rdy});
         chk("d3_out_valid", {63'd0, vld3}, {63'd0, e_vld});
         chk("d3_out_data",  dat3, e_dat);
         chk("d3_count",     {62'd0, cnt3}, 64'(m3.size()));
      end
      if (rst || flush) begin
         m3.delete();
      end else if (!byp) begin
         if ((m3.size() != 0) && out_ready) void'(m3.pop_front());
         if (in_valid && e_rdy) m3.push_back(in_data);
      end
   end

   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [63:0] d, input logic ordy);
      rst       = r;
      flush     = f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      chk_en = 1'b0;

      // Reset held 3 cycles with a pending producer.
      for (int i = 0; i < 3; i++) drive(1, 0, 1, 64'hDEAD, 0);
      drive(0, 0, 0, 64'h0, 0);

      // Fill / drain: DEPTH=2 fills at 0xA,0xB and refuses 0xC.
      drive(0, 0, 1, 64'hA, 0);
      drive(0, 0, 1, 64'hB, 0);
      drive(0, 0, 1, 64'hC, 0);
      drive(0, 0, 0, 64'h0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 0, 64'h0, 1);

      // Simultaneous push/pop with one entry held.
      drive(0, 0, 1, 64'h5, 0);
      drive(0, 0, 1, 64'h6, 1);
      drive(0, 0, 0, 64'h0, 0);
      for (int i = 0; i < 2; i++) drive(0, 0, 0, 64'h0, 1);

      // Flush with two entries and a same-cycle push of 0x7.
      drive(0, 0, 1, 64'h1, 0);
      drive(0, 0, 1, 64'h2, 0);
      drive(0, 1, 1, 64'h7, 1);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 64'h0, 1);

      // Empty buffer, ready consumer: same-cycle only in the bypass build.
      drive(0, 0, 1, 64'h1234, 1);
      for (int i = 0; i < 2; i++) drive(0, 0, 0, 64'h0, 1);

      // Wrap: 1..10 through the DEPTH=3 instance with random consumer.
      for (int v = 1; v <= 10; v++) begin
         bit acc;
         int guard;
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 50) begin
            rst       = 1'b0;
            flush     = 1'b0;
            in_valid  = 1'b1;
            in_data   = 64'(v);
            out_ready = 1'($urandom_range(0, 1));
            acc       = rdy3;
            @(posedge clk);
            #1;
            guard++;
         end
         if (!acc) chk("wrap_accept_timeout", 64'd0, 64'd1);
      end
      for (int i = 0; i < 6; i++) drive(0, 0, 0, 64'h0, 1);

      // Randomized traffic with rare reset and flush.
      for (int i = 0; i < 2000; i++) begin
         drive(($urandom_range(0, 63) == 0),
               ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0),
               {$urandom, $urandom},
               1'($urandom_range(0, 1)));
      end
      drive(0, 0, 0, 64'h0, 1);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
